univ_reg: RTL and testbench
===========================

# univ_reg

Parametrised universal register for the sequential-logic toolkit. It supports hold, parallel load, shift, rotate and up/down counting. It keeps the single flip-flop's asynchronous reset/set and clock-enable semantics, but across `WIDTH` bits with a selectable operating mode. Datapaths and exercise top-levels use it wherever a plain register, shift register or counter is needed.

## Interface
Parameters:
- `WIDTH`, 8: register width in bits, legal values 2 or more.
- `RESET_VALUE`, 0: value forced onto `q` by `reset`.
- `SET_VALUE`, all ones: value forced onto `q` by `set`.

Ports:
- `clk`  in  1: clock; all synchronous updates occur on the rising edge.
- `reset`  in  1: asynchronous, active-high. Forces `q = RESET_VALUE` and `sout = 0`.
- `set`  in  1: asynchronous, active-high. Forces `q = SET_VALUE` and `sout = 0`. `reset` takes priority over `set`.
- `enable`  in  1: synchronous clock enable. When 0, `q` and `sout` hold.
- `mode`  in  3: operation selector (see Operation).
- `d`  in  WIDTH: parallel load data.
- `sin_r`  in  1: serial input for shift right; enters at the MSB.
- `sin_l`  in  1: serial input for shift left; enters at the LSB.
- `q`  out  WIDTH: register contents.
- `qn`  out  WIDTH: bitwise complement of `q` (combinational).
- `sout`  out  1: registered copy of the bit that left the register on the last shift or rotate.
- `tc`  out  1: terminal count flag (combinational).

## Operation
Priority order on every evaluation:
1. `reset`
2. `set`
3. `enable`
4. the `mode` decode

The following applies only at a rising `clk` edge with `reset = 0`, `set = 0` and `enable = 1`:
- `000` hold: `q` unchanged; `sout` unchanged.
- `001` load: `q <= d`; `sout` unchanged.
- `010` shift right: `q <= {sin_r, q[WIDTH-1:1]}`; `sout <= q[0]`.
- `011` shift left: `q <= {q[WIDTH-2:0], sin_l}`; `sout <= q[WIDTH-1]`.
- `100` rotate right: `q <= {q[0], q[WIDTH-1:1]}`; `sout <= q[0]`.
- `101` rotate left: `q <= {q[WIDTH-2:0], q[WIDTH-1]}`; `sout <= q[WIDTH-1]`.
- `110` count up: `q <= q + 1`, modulo 2^WIDTH; all ones wraps to 0. `sout` unchanged.
- `111` count down: `q <= q - 1`, modulo 2^WIDTH; 0 wraps to all ones. `sout` unchanged.

Flag and output rules:
- `tc` = `enable & ((mode==110 & q==all ones) | (mode==111 & q==0))`. It is asserted during the cycle whose edge wraps the counter, so cascading stages can use `tc` as their `enable`.
- `qn` is always exactly `~q`, including during reset and set.
- No state machine beyond the register itself. `mode` is sampled only at the clock edge, so changing it between edges has no effect on `q` until the next edge.

## Timing
- Reset values: `q = RESET_VALUE`, `qn = ~RESET_VALUE`, `sout = 0`. `tc` follows its equation (1 if `enable`, `mode = 111` and `RESET_VALUE = 0`).
- Asserting `reset` or `set` changes `q` immediately, with no clock required. `q` holds that value for as long as the signal stays asserted, regardless of `clk`, `enable` or `mode`.
- Simultaneous `reset` and `set`: `reset` wins; `q = RESET_VALUE`.
- Releasing `reset` while `set` is still high: `q` goes asynchronously to `SET_VALUE`.
- After both are released, the first rising `clk` edge performs the normal mode operation.
- Assertion mid-operation, for example during a count: the in-progress value is discarded. Counting resumes from the forced value.
- Synchronous latency is one clock: `q` and `sout` reflect an operation immediately after the edge that performs it.
- `tc` and `qn` add no register stage.

## Test plan
- Reset and set: `WIDTH=8`, `RESET_VALUE=8'h00`, `SET_VALUE=8'hFF`.
  - Pulse `set` between clock edges → `q=FF` with no edge, `sout=0`.
  - Assert `reset` while `set=1` → `q=00`.
  - Release `reset` with `set` still high → `q=FF`.
- Load and hold:
  - `mode=001`, `d=A5`, one edge → `q=A5`, `qn=5A`.
  - `enable=0`, `mode=001`, `d=3C`, edge → `q` stays `A5`.
  - `mode=000` with `enable=1` → `q` stays `A5`.
- Shift and rotate, starting from `q=A5`:
  - Shift right, `sin_r=1` → `q=D2`, `sout=1`.
  - Then shift left, `sin_l=0` → `q=A4`, `sout=1`.
  - Then rotate right ×8 → `q` returns to `A4`.
- Count up wrap:
  - Load `FE`, then `mode=110`. Edge → `FF` with `tc=1` before the next edge. Next edge → `q=00`, `tc=0`.
- Count down wrap:
  - Load `01`, then `mode=111`. Edge → `q=00`, `tc=1`. Next edge → `q=FF`.
  - Assert `reset` mid-count → `q=00` immediately. Counting resumes from `00` after release.
- Cascade: two `WIDTH=4` instances, the upper's `enable` tied to the lower's `tc`, both `mode=110`.
  - 256 edges from 0 → combined value sweeps `00..FF` and wraps to `00`.

Source files
------------

// File: rtl/univ_reg.sv
// Universal WIDTH-bit register: hold, load, shift, rotate and up/down count,
// with asynchronous reset/set (reset dominant) and a synchronous clock enable.
module univ_reg #(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] SET_VALUE   = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             sout,
  output logic             tc
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_SHL  = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_UP   = 3'b110;
  localparam logic [2:0] M_DN   = 3'b111;

  // set is gated by ~reset so that releasing reset while set is held produces
  // a rising edge here, forcing SET_VALUE without waiting for a clock.
  logic set_only;
  assign set_only = set & ~reset;

  always_ff @(posedge clk or posedge reset or posedge set_only) begin
    if (reset) begin
      q    <= RESET_VALUE;
      sout <= 1'b0;
    end else if (set_only) begin
      q    <= SET_VALUE;
      sout <= 1'b0;
    end else if (enable) begin
      case (mode)
        M_HOLD: q <= q;
        M_LOAD: q <= d;
        M_SHR: begin
          q    <= {sin_r, q[WIDTH-1:1]};
          sout <= q[0];
        end
        M_SHL: begin
          q    <= {q[WIDTH-2:0], sin_l};
          sout <= q[WIDTH-1];
        end
        M_ROR: begin
          q    <= {q[0], q[WIDTH-1:1]};
          sout <= q[0];
        end
        M_ROL: begin
          q    <= {q[WIDTH-2:0], q[WIDTH-1]};
          sout <= q[WIDTH-1];
        end
        M_UP:  q <= q + 1'b1;
        M_DN:  q <= q - 1'b1;
        default: q <= q;
      endcase
    end
  end

  assign qn = ~q;
  // Combinational so a cascaded stage can use it as its enable on the wrap edge.
  assign tc = enable & (((mode == M_UP) & (&q)) | ((mode == M_DN) & ~(|q)));

endmodule

// File: tb/tb_univ_reg.sv
// Self-checking bench for univ_reg: directed reset/set/load/shift/count steps,
// randomized operations against an arithmetic model, and a 2x4-bit cascade.
module tb_univ_reg;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, set, enable, sin_r, sin_l;
  logic [2:0]   mode;
  logic [W-1:0] d, q, qn;
  logic         sout, tc;

  logic         creset, cen;
  logic [3:0]   lo_q, hi_q, lo_qn, hi_qn;
  logic         lo_tc, hi_tc, lo_sout, hi_sout;

  int n_chk  = 0;
  int n_fail = 0;
  int mq;
  int msout;

  always #5 clk = ~clk;

  univ_reg #(.WIDTH(W), .RESET_VALUE(8'h00), .SET_VALUE(8'hFF)) dut (
    .clk(clk), .reset(reset), .set(set), .enable(enable), .mode(mode), .d(d),
    .sin_r(sin_r), .sin_l(sin_l), .q(q), .qn(qn), .sout(sout), .tc(tc)
  );

  univ_reg #(.WIDTH(4)) u_lo (
    .clk(clk), .reset(creset), .set(1'b0), .enable(cen), .mode(3'b110), .d(4'h0),
    .sin_r(1'b0), .sin_l(1'b0), .q(lo_q), .qn(lo_qn), .sout(lo_sout), .tc(lo_tc)
  );

  univ_reg #(.WIDTH(4)) u_hi (
    .clk(clk), .reset(creset), .set(1'b0), .enable(lo_tc), .mode(3'b110), .d(4'h0),
    .sin_r(1'b0), .sin_l(1'b0), .q(hi_q), .qn(hi_qn), .sout(hi_sout), .tc(hi_tc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: what one enabled edge does, in plain integer arithmetic.
  function automatic void model_edge();
    if (!enable) return;
    case (mode)
      3'd1: mq = int'(d);
      3'd2: begin msout = mq % 2;   mq = int'(sin_r) * 128 + mq / 2; end
      3'd3: begin msout = mq / 128; mq = (mq * 2 + int'(sin_l)) % 256; end
      3'd4: begin msout = mq % 2;   mq = (mq % 2) * 128 + mq / 2; end
      3'd5: begin msout = mq / 128; mq = (mq * 2 + mq / 128) % 256; end
      3'd6: mq = (mq + 1) % 256;
      3'd7: mq = (mq + 255) % 256;
      default: ;
    endcase
  endfunction

  function automatic int exp_tc();
    return (enable && ((mode == 3'd6 && mq == 255) || (mode == 3'd7 && mq == 0))) ? 1 : 0;
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".q"}, q, mq);
    chk({tag, ".qn"}, qn, (~mq) & 255);
    chk({tag, ".sout"}, sout, msout);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; set = 1'b0; enable = 1'b0; mode = 3'd0; d = '0;
    sin_r = 1'b0; sin_l = 1'b0; creset = 1'b1; cen = 1'b0;
    mq = 0; msout = 0;
    #3;
    chk_state("reset");
    chk("reset.tc_off", tc, 0);
    enable = 1'b1; mode = 3'd7; #1;
    chk("reset.tc_dn", tc, 1);
    enable = 1'b0; mode = 3'd0; #1;
    reset = 1'b0;

    // Asynchronous set/reset interplay between edges
    @(negedge clk);
    set = 1'b1; #1;
    chk("set.q", q, 8'hFF);
    chk("set.sout", sout, 0);
    reset = 1'b1; #1;
    chk("reset_over_set.q", q, 8'h00);
    reset = 1'b0; #1;
    chk("reset_release.q", q, 8'hFF);
    set = 1'b0; #1;
    chk("set_release.q", q, 8'hFF);
    mq = 255; msout = 0;

    // Load and hold
    @(posedge clk); #1;
    enable = 1'b1; mode = 3'd1; d = 8'hA5; step(); chk_state("load");
    chk("load.lit", q, 8'hA5);
    enable = 1'b0; d = 8'h3C; step(); chk_state("en_off");
    enable = 1'b1; mode = 3'd0; step(); chk_state("hold");

    // Shift / rotate
    mode = 3'd2; sin_r = 1'b1; step(); chk_state("shr");
    chk("shr.lit", q, 8'hD2);
    mode = 3'd3; sin_l = 1'b0; step(); chk_state("shl");
    chk("shl.lit", q, 8'hA4);
    mode = 3'd4;
    for (int i = 0; i < 8; i++) step();
    chk_state("ror8");
    chk("ror8.lit", q, 8'hA4);

    // Count up wrap
    mode = 3'd1; d = 8'hFE; step();
    mode = 3'd6; #1;
    chk("up.tc_fe", tc, 0);
    step(); chk_state("up_ff");
    chk("up.tc_ff", tc, 1);
    step(); chk_state("up_wrap");
    chk("up.tc_00", tc, 0);

    // Count down wrap and mid-count reset
    mode = 3'd1; d = 8'h01; step();
    mode = 3'd7; step(); chk_state("dn_00");
    chk("dn.tc_00", tc, 1);
    step(); chk_state("dn_wrap");
    chk("dn.wrap.lit", q, 8'hFF);
    step(); step();
    reset = 1'b1; #1;
    chk("midcount_reset.q", q, 8'h00);
    chk("midcount_reset.sout", sout, 0);
    @(posedge clk); #1;
    chk("reset_held.q", q, 8'h00);
    reset = 1'b0; mq = 0; msout = 0;
    step(); chk_state("dn_resume");

    // Randomized operations against the model
    for (int i = 0; i < 300; i++) begin
      enable = ($urandom_range(0, 7) != 0);
      mode   = 3'($urandom_range(0, 7));
      d      = 8'($urandom);
      sin_r  = 1'($urandom);
      sin_l  = 1'($urandom);
      #1;
      chk("rand.tc", tc, exp_tc());
      step();
      chk_state("rand");
    end

    // Cascade of two 4-bit counters
    enable = 1'b0;
    creset = 1'b0; cen = 1'b1;
    for (int i = 0; i < 256; i++) begin
      chk("cascade", {hi_q, lo_q}, i);
      @(posedge clk); #1;
    end
    chk("cascade.wrap", {hi_q, lo_q}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
